// File: rtl/uart_pkg.sv
// Shared UART receiver definitions. Defining UART_RX_PARITY_EN adds the PARITY
// state used for 8E1 framing.
package uart_pkg;

  localparam int UART_DATA_BITS         = 8;
  localparam int DEFAULT_CLOCKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte buffer: power-of-two circular FIFO that accepts a simultaneous
// push and pop while full. The head reads as zero while the FIFO is empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage is deliberately left without reset; count and pointers alone
  // decide which entries are live, and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// small byte FIFO with valid/ready output and one-cycle error pulses.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_RX_Serial,
  input  logic                      i_RX_Ready,
  output logic                      o_RX_Data_Valid,
  output logic [UART_DATA_BITS-1:0] o_RX_Byte,
  output logic                      o_Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic                      o_Parity_Err,
`endif
  output logic                      o_Overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_e                 r_state;
  rx_state_e                 w_state_next;
  logic                      r_sync1;
  logic                      r_sync2;
  logic [CNT_W-1:0]          r_clk_cnt;
  logic [BIT_W-1:0]          r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;
  logic                      r_overrun;
  logic                      w_rx;
  logic                      w_cnt_clr;
  logic                      w_data_sample;
  logic                      w_stop_sample;
  logic                      w_parity_bad;
  logic                      w_good;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
    end else begin
      r_sync1 <= i_RX_Serial;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_sample;
  logic r_parity_bit;
  logic r_parity_err;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_clr     = 1'b0;
    w_data_sample = 1'b0;
    w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx) w_state_next = START;
      end
      START: begin
        if (r_clk_cnt == MID_CNT) begin
          w_cnt_clr    = 1'b1;
          w_state_next = w_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_cnt == BIT_CNT) begin
          w_cnt_clr     = 1'b1;
          w_data_sample = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == LAST_BIT) w_state_next = PARITY;
`else
          if (r_bit_idx == LAST_BIT) w_state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_clk_cnt == BIT_CNT) begin
          w_cnt_clr    = 1'b1;
          w_par_sample = 1'b1;
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE on the sample edge lets a start bit right after
        // mid-stop be caught without losing a cycle.
        if (r_clk_cnt == BIT_CNT) begin
          w_cnt_clr     = 1'b1;
          w_stop_sample = 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit must hold an even number of ones.
  assign w_parity_bad = ^{r_shift, r_parity_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_bit <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) r_parity_bit <= w_rx;
      r_parity_err <= w_stop_sample && w_parity_bad;
    end
  end

  assign o_Parity_Err = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
`endif

  assign w_good = w_stop_sample && w_rx && !w_parity_bad;
  assign w_pop  = i_RX_Ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_clk_cnt <= w_cnt_clr ? '0 : r_clk_cnt + CNT_W'(1);
      if (r_state != DATA)    r_bit_idx <= '0;
      else if (w_data_sample) r_bit_idx <= r_bit_idx + BIT_W'(1);
      if (w_data_sample) r_shift <= {w_rx, r_shift[UART_DATA_BITS-1:1]};
      r_frame_err <= w_stop_sample && !w_rx;
      r_overrun   <= w_good && w_full && !w_pop;
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_good),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_head  (o_RX_Byte),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_RX_Data_Valid = !w_empty;
  assign o_Frame_Err     = r_frame_err;
  assign o_Overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed frames plus randomized
// traffic compared every cycle against a queue-based model of frame outcomes.
`timescale 1ns/1ps
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int CPB   = 217;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int SYNC_LAT    = 2;
  localparam int CYCLE_LIMIT = 95000;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       i_RX_Serial = 1'b1;
  logic       i_RX_Ready  = 1'b0;
  logic       o_RX_Data_Valid;
  logic [7:0] o_RX_Byte;
  logic       o_Frame_Err;
  logic       o_Overrun;
  logic       w_parity_err;

  uart_rx_buffered #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_RX_Serial     (i_RX_Serial),
    .i_RX_Ready      (i_RX_Ready),
    .o_RX_Data_Valid (o_RX_Data_Valid),
    .o_RX_Byte       (o_RX_Byte),
    .o_Frame_Err     (o_Frame_Err),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err    (w_parity_err),
`endif
    .o_Overrun       (o_Overrun)
  );

`ifndef UART_RX_PARITY_EN
  assign w_parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: each sent frame is reduced to the edge at which its stop bit is
  // judged and its outcome; the buffer is a plain bounded queue.
  typedef struct {
    int         edge_no;
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
  } frame_t;

  frame_t     ev_q[$];
  logic [7:0] m_q[$];
  bit         m_fe, m_ov, m_pe, m_pop;
  frame_t     m_f;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      ev_q.delete();
    end else begin
      m_pop = i_RX_Ready && (m_q.size() > 0);
      if (ev_q.size() > 0 && ev_q[0].edge_no == cyc) begin
        m_f  = ev_q.pop_front();
        m_fe = !m_f.stop_ok;
        m_pe = !m_f.par_ok;
        if (m_f.stop_ok && m_f.par_ok) begin
          if (m_q.size() == DEPTH && !m_pop) m_ov = 1'b1;
          else m_q.push_back(m_f.data);
        end
      end
      if (m_pop) void'(m_q.pop_front());
    end
  end

  // Observations of the DUT for the directed literal checks.
  logic [7:0] pop_log[$];
  int fe_cnt, ov_cnt, pe_cnt, valid_cnt;
  logic [11:0] exp_vec, act_vec;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_vec = {m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 8'h00, m_fe, m_ov, m_pe};
      act_vec = {o_RX_Data_Valid, o_RX_Data_Valid ? o_RX_Byte : 8'h00,
                 o_Frame_Err, o_Overrun, w_parity_err};
      check($sformatf("outputs@%0d", cyc), 32'(act_vec), 32'(exp_vec));
      if (o_RX_Data_Valid && i_RX_Ready) pop_log.push_back(o_RX_Byte);
      if (o_RX_Data_Valid) valid_cnt++;
      if (o_Frame_Err)     fe_cnt++;
      if (o_Overrun)       ov_cnt++;
      if (w_parity_err)    pe_cnt++;
    end
  end

  // Ready driver: 0 = low, 1 = high, 2 = random each cycle.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) i_RX_Ready = 1'($urandom_range(0, 1));
    else               i_RX_Ready = (rdy_mode == 1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    i_RX_Serial = 1'b1;
    tick(n);
  endtask

  task automatic clear_obs();
    pop_log.delete();
    fe_cnt    = 0;
    ov_cnt    = 0;
    pe_cnt    = 0;
    valid_cnt = 0;
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < pop_log.size()) return 32'(pop_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    logic [FRAME_BITS-2:0] bits;
    frame_t f;
    bits      = '0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^d) ^ !par_ok;
`endif
    tick(1);
    // First edge seeing the start bit is cyc+1; two sync flops, half a bit
    // to the start mid-point, then one bit time per remaining frame bit.
    f.edge_no = cyc + 1 + SYNC_LAT + CPB / 2 + CPB * (FRAME_BITS - 1);
    f.data    = d;
    f.stop_ok = stop_ok;
    f.par_ok  = par_ok;
    ev_q.push_back(f);
    for (int i = 0; i < FRAME_BITS - 1; i++) begin
      i_RX_Serial = bits[i];
      tick(CPB);
    end
    if (stop_ok) begin
      i_RX_Serial = 1'b1;
      tick(CPB);
    end else begin
      // Bad stop bit is released before a fresh start could be mistaken.
      i_RX_Serial = 1'b0;
      tick(CPB * 3 / 4);
      idle(CPB);
    end
  endtask

  initial begin
    #(CYCLE_LIMIT * 10);
    $display("FAIL watchdog actual=%0d cycles required=<%0d", cyc, CYCLE_LIMIT);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit sok, pok;
    int gap;
    clear_obs();
    tick(3);
    check("rst_valid", 32'(o_RX_Data_Valid), 32'd0);
    check("rst_byte",  32'(o_RX_Byte),       32'h00);
    check("rst_ferr",  32'(o_Frame_Err),     32'd0);
    check("rst_ovr",   32'(o_Overrun),       32'd0);
    check("rst_perr",  32'(w_parity_err),    32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single good byte, consumer always ready.
    clear_obs();
    rdy_mode = 1;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(50);
    check("a5_count", pop_log.size(), 32'd1);
    check("a5_byte",  pop_at(0),      32'hA5);
    check("a5_valid_cycles", valid_cnt, 32'd1);
    check("a5_flags", fe_cnt + ov_cnt + pe_cnt, 32'd0);

    // Start glitch shorter than half a bit.
    clear_obs();
    i_RX_Serial = 1'b0;
    tick(60);
    idle(2 * CPB);
    check("glitch_valid", valid_cnt, 32'd0);
    check("glitch_flags", fe_cnt + ov_cnt + pe_cnt, 32'd0);
    check("glitch_idle",  32'(dut.r_state), 32'(IDLE));

    // Framing error.
    clear_obs();
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(CPB);
    check("ferr_pulses", fe_cnt,    32'd1);
    check("ferr_valid",  valid_cnt, 32'd0);

    // Overrun on fifth byte with consumer stalled, then drain in order.
    clear_obs();
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
    idle(CPB);
    check("ovr_pulses", ov_cnt, 32'd1);
    rdy_mode = 1;
    idle(20);
    check("ovr_count", pop_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr_byte%0d", i), pop_at(i), 32'(i + 1));

    // Reset during data bit 4 of 0xFF, then 0x42.
    clear_obs();
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        tick(CPB * 5 + 50);
        rst_n = 1'b0;
        tick(1);
        check("midrst_valid", 32'(o_RX_Data_Valid), 32'd0);
        check("midrst_state", 32'(dut.r_state),     32'(IDLE));
        tick(2);
        rst_n = 1'b1;
      end
    join
    idle(CPB);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(50);
    check("midrst_count", pop_log.size(), 32'd1);
    check("midrst_byte",  pop_at(0),      32'h42);
    check("midrst_ferr",  fe_cnt,         32'd0);

`ifdef UART_RX_PARITY_EN
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(50);
    check("par_bad_pulses", pe_cnt,         32'd1);
    check("par_bad_count",  pop_log.size(), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(50);
    check("par_ok_count", pop_log.size(), 32'd1);
    check("par_ok_byte",  pop_at(0),      32'h07);
`endif

    // Randomized traffic with random consumer stalls.
    rdy_mode = 2;
    for (int n = 0; n < 12; n++) begin
      gap = $urandom_range(0, 300);
      if ($urandom_range(0, 5) == 0) begin
        i_RX_Serial = 1'b0;
        tick($urandom_range(1, 90));
        idle(CPB);
      end
      sok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 7) != 0);
`else
      pok = 1'b1;
`endif
      send_frame(8'($urandom_range(0, 255)), sok, pok);
      idle(gap);
    end
    rdy_mode = 1;
    idle(50);
    check("drain_valid", 32'(o_RX_Data_Valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
